atmega_spi_s: RTL and testbench

SPI slave peripheral with the ATmega SPCR/SPSR/SPDR register model, the responder counterpart to the ATmega SPI master on the same I/O bus. It samples an external master's SCK/SS#/MOSI in the `clk` domain, shifts one byte per transfer, drives MISO, and raises SPIF/interrupt on each completed byte. It sits on the core I/O bus next to the other ATmega peripherals.

---
 rtl/atmega_spi_pkg.sv | 41 ++++
 rtl/atmega_spi_sync.sv | 39 +++
 rtl/atmega_spi_s.sv | 219 +++++++++++++++++++++
 tb/tb_atmega_spi_s.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/atmega_spi_pkg.sv
// Shared ATmega SPI definitions: SPCR/SPSR bit positions, transfer FSM state
// and byte shift helpers used by the master and slave blocks.
package atmega_spi_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 3;

    // SPCR bit positions
    localparam int unsigned SPIE_BIT = 7;
    localparam int unsigned SPE_BIT  = 6;
    localparam int unsigned DORD_BIT = 5;
    localparam int unsigned CPOL_BIT = 3;
    localparam int unsigned CPHA_BIT = 2;

    // SPSR bit positions
    localparam int unsigned SPIF_BIT = 7;
    localparam int unsigned WCOL_BIT = 6;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

    // Advance a transmit byte by one bit in the selected order
    function automatic logic [DATA_W-1:0] spi_shift_out(
        input logic [DATA_W-1:0] d,
        input logic              lsb_first
    );
        return lsb_first ? {1'b0, d[DATA_W-1:1]} : {d[DATA_W-2:0], 1'b0};
    endfunction

    // Insert one received bit; LSB-first fills from the top so bit 0 ends lowest
    function automatic logic [DATA_W-1:0] spi_shift_in(
        input logic [DATA_W-1:0] d,
        input logic              din,
        input logic              lsb_first
    );
        return lsb_first ? {din, d[DATA_W-1:1]} : {d[DATA_W-2:0], din};
    endfunction

endpackage

// File: rtl/atmega_spi_sync.sv
// Two-flop synchronizer for one asynchronous SPI pin, with rise/fall pulses
// derived from the synchronized level and its previous sample.
module atmega_spi_sync (
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic din,
    output logic dout,
    output logic rise_c,
    output logic fall_c
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic prev_q, prev_d;

    always_comb begin
        s1_d   = din;
        s2_d   = s1_q;
        prev_d = s2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= rst_val;
            s2_q   <= rst_val;
            prev_q <= rst_val;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
        end
    end

    assign dout   = s2_q;
    assign rise_c = s2_q & ~prev_q;
    assign fall_c = ~s2_q & prev_q;

endmodule

// File: rtl/atmega_spi_s.sv
// ATmega-style SPI slave with SPCR/SPSR/SPDR on the core I/O bus.
// Define ATMEGA_SPI_S_WCOL_EN to flag SPDR writes that land mid-byte as WCOL.
module atmega_spi_s
    import atmega_spi_pkg::*;
#(
    parameter int unsigned BUS_ADDR_DATA_LEN = 6,
    parameter int unsigned SPCR_ADDR         = 0,
    parameter int unsigned SPSR_ADDR         = 1,
    parameter int unsigned SPDR_ADDR         = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [BUS_ADDR_DATA_LEN-1:0] addr,
    input  logic                         wr,
    input  logic                         rd,
    input  logic [7:0]                   bus_in,
    output logic [7:0]                   bus_out,
    output logic                         int_out,
    input  logic                         int_rst,
    output logic                         io_connect,
    input  logic                         sck,
    input  logic                         ss_n,
    input  logic                         mosi,
    output logic                         miso,
    output logic                         miso_oe
);

    spi_state_e state_q, state_d;

    logic [DATA_W-1:0] spcr_q, spcr_d;
    logic [DATA_W-1:0] tx_hold_q, tx_hold_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] rx_buf_q, rx_buf_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              spif_q, spif_d;
    logic              wcol_q, wcol_d;
    logic              arm_q, arm_d;

    logic spie, spe, dord, cpol, cpha;
    logic spcr_sel, spsr_sel, spdr_sel, spdr_access;
    logic sck_level_unused, sck_rise, sck_fall;
    logic ss_n_sync, ss_rise, ss_fall;
    logic mosi_sync, mosi_rise_unused, mosi_fall_unused;
    logic lead_edge, trail_edge, sample_edge, shift_edge;
    logic xfer_start, xfer_live, byte_done, wcol_hit, flag_clr;
    logic [DATA_W-1:0] rx_next;
    logic [DATA_W-1:0] spsr_val;

    assign spie = spcr_q[SPIE_BIT];
    assign spe  = spcr_q[SPE_BIT];
    assign dord = spcr_q[DORD_BIT];
    assign cpol = spcr_q[CPOL_BIT];
    assign cpha = spcr_q[CPHA_BIT];

    assign spcr_sel    = (addr == BUS_ADDR_DATA_LEN'(SPCR_ADDR));
    assign spsr_sel    = (addr == BUS_ADDR_DATA_LEN'(SPSR_ADDR));
    assign spdr_sel    = (addr == BUS_ADDR_DATA_LEN'(SPDR_ADDR));
    assign spdr_access = (rd | wr) & spdr_sel;

    atmega_spi_sync u_sck_sync (
        .clk     (clk),
        .rst     (rst),
        .rst_val (cpol),
        .din     (sck),
        .dout    (sck_level_unused),
        .rise_c  (sck_rise),
        .fall_c  (sck_fall)
    );

    atmega_spi_sync u_ss_sync (
        .clk     (clk),
        .rst     (rst),
        .rst_val (1'b1),
        .din     (ss_n),
        .dout    (ss_n_sync),
        .rise_c  (ss_rise),
        .fall_c  (ss_fall)
    );

    atmega_spi_sync u_mosi_sync (
        .clk     (clk),
        .rst     (rst),
        .rst_val (1'b1),
        .din     (mosi),
        .dout    (mosi_sync),
        .rise_c  (mosi_rise_unused),
        .fall_c  (mosi_fall_unused)
    );

    // Leading edge leaves the CPOL idle level; CPHA picks which edge samples
    assign lead_edge   = cpol ? sck_fall : sck_rise;
    assign trail_edge  = cpol ? sck_rise : sck_fall;
    assign sample_edge = cpha ? trail_edge : lead_edge;
    assign shift_edge  = cpha ? lead_edge : trail_edge;

    assign xfer_start = (state_q == ST_IDLE) & spe & ss_fall;
    assign xfer_live  = (state_q == ST_ACTIVE) & spe & ~ss_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (ss_fall) state_d = ST_ACTIVE;
            ST_ACTIVE: if (ss_rise) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (!spe) state_d = ST_IDLE;
    end

    always_comb begin
        spcr_d     = spcr_q;
        tx_hold_d  = tx_hold_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_buf_d   = rx_buf_q;
        bit_cnt_d  = bit_cnt_q;
        spif_d     = spif_q;
        wcol_d     = wcol_q;
        arm_d      = arm_q;
        rx_next    = spi_shift_in(rx_shift_q, mosi_sync, dord);
        byte_done  = 1'b0;

        if (wr && spcr_sel) spcr_d = bus_in;

`ifdef ATMEGA_SPI_S_WCOL_EN
        wcol_hit = wr & spdr_sel & (state_q == ST_ACTIVE) & (bit_cnt_q != '0);
`else
        wcol_hit = 1'b0;
`endif
        if (wr && spdr_sel && !wcol_hit) tx_hold_d = bus_in;

        // Transfer engine; any exit from a live byte drops the partial count
        if (xfer_start) begin
            tx_shift_d = tx_hold_q;
            bit_cnt_d  = '0;
        end else if (!xfer_live) begin
            bit_cnt_d = '0;
        end else if (sample_edge) begin
            rx_shift_d = rx_next;
            if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                rx_buf_d  = rx_next;
                byte_done = 1'b1;
                bit_cnt_d = '0;
                if (!cpha) tx_shift_d = tx_hold_q;
            end else begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end else if (shift_edge) begin
            // At a byte boundary CPHA=1 reloads here instead of shifting
            if (bit_cnt_q != '0) begin
                tx_shift_d = spi_shift_out(tx_shift_q, dord);
            end else if (cpha) begin
                tx_shift_d = tx_hold_q;
            end
        end

        // Flag clear first so a completing byte or collision wins the cycle
        flag_clr = int_rst | (arm_q & spdr_access);
        if (flag_clr) begin
            spif_d = 1'b0;
            wcol_d = 1'b0;
        end
        if (byte_done) spif_d = 1'b1;
        if (wcol_hit)  wcol_d = 1'b1;

        if (spdr_access || int_rst) arm_d = 1'b0;
        if (rd && spsr_sel && (spif_q || wcol_q)) arm_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            spcr_q     <= '0;
            tx_hold_q  <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_buf_q   <= '0;
            bit_cnt_q  <= '0;
            spif_q     <= 1'b0;
            wcol_q     <= 1'b0;
            arm_q      <= 1'b0;
        end else begin
            spcr_q     <= spcr_d;
            tx_hold_q  <= tx_hold_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_buf_q   <= rx_buf_d;
            bit_cnt_q  <= bit_cnt_d;
            spif_q     <= spif_d;
            wcol_q     <= wcol_d;
            arm_q      <= arm_d;
        end
    end

    always_comb begin
        spsr_val           = '0;
        spsr_val[SPIF_BIT] = spif_q;
        spsr_val[WCOL_BIT] = wcol_q;
        bus_out            = '0;
        if (rd) begin
            if (spcr_sel)      bus_out = spcr_q;
            else if (spsr_sel) bus_out = spsr_val;
            else if (spdr_sel) bus_out = rx_buf_q;
        end
    end

    assign io_connect = spe;
    assign miso_oe    = spe & ~ss_n_sync;
    assign miso       = miso_oe ? (dord ? tx_shift_q[0] : tx_shift_q[DATA_W-1]) : 1'b1;
    assign int_out    = spie & spif_q;

endmodule

// File: tb/tb_atmega_spi_s.sv
// Bench for atmega_spi_s: drives an SPI master on the pins and the I/O bus,
// comparing against a transaction-level model of the register file.
`timescale 1ns/1ps
module tb_atmega_spi_s;

    localparam int unsigned H = 8;
    localparam logic [5:0] A_SPCR = 6'd0;
    localparam logic [5:0] A_SPSR = 6'd1;
    localparam logic [5:0] A_SPDR = 6'd2;
`ifdef ATMEGA_SPI_S_WCOL_EN
    localparam bit WCOL_EN = 1'b1;
`else
    localparam bit WCOL_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, wr, rd, int_rst, sck, ss_n, mosi;
    logic [5:0] addr;
    logic [7:0] bus_in, bus_out;
    logic       int_out, io_connect, miso, miso_oe;

    int n_checks = 0;
    int n_fail   = 0;

    logic       m_cpol, m_cpha, m_dord;
    logic [7:0] m_rx;

    // Transaction-level model of the slave's visible state
    logic [7:0] mdl_tx_hold, mdl_rx_buf, mdl_loaded;
    logic       mdl_spif, mdl_wcol, mdl_armed;

    typedef struct {
        logic [1:0] mode;
        logic       dord;
        logic       spie;
        logic [7:0] tx;
        logic [7:0] mo;
        logic [7:0] exp_miso;
        logic [7:0] exp_spdr;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    atmega_spi_s dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .wr         (wr),
        .rd         (rd),
        .bus_in     (bus_in),
        .bus_out    (bus_out),
        .int_out    (int_out),
        .int_rst    (int_rst),
        .io_connect (io_connect),
        .sck        (sck),
        .ss_n       (ss_n),
        .mosi       (mosi),
        .miso       (miso),
        .miso_oe    (miso_oe)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] mdl_spsr();
        return {mdl_spif, mdl_wcol, 6'b0};
    endfunction

    task automatic host_rd(input logic [5:0] a, output logic [7:0] d);
        @(negedge clk);
        addr = a;
        rd   = 1'b1;
        #1 d = bus_out;
        @(negedge clk);
        rd = 1'b0;
        if (a == A_SPDR) begin
            if (mdl_armed) begin
                mdl_spif = 1'b0;
                mdl_wcol = 1'b0;
            end
            mdl_armed = 1'b0;
        end else if (a == A_SPSR && (mdl_spif || mdl_wcol)) begin
            mdl_armed = 1'b1;
        end
    endtask

    task automatic host_wr(input logic [5:0] a, input logic [7:0] v, input bit mid);
        @(negedge clk);
        addr   = a;
        bus_in = v;
        wr     = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        if (a == A_SPDR) begin
            if (mdl_armed) begin
                mdl_spif = 1'b0;
                mdl_wcol = 1'b0;
            end
            mdl_armed = 1'b0;
            if (mid && WCOL_EN) mdl_wcol = 1'b1;
            else                mdl_tx_hold = v;
        end
    endtask

    task automatic pulse_int_rst();
        @(negedge clk);
        int_rst = 1'b1;
        @(negedge clk);
        int_rst = 1'b0;
        mdl_spif  = 1'b0;
        mdl_wcol  = 1'b0;
        mdl_armed = 1'b0;
    endtask

    task automatic set_mode(input logic [1:0] mode, input logic dord, input logic spie);
        m_cpol = mode[1];
        m_cpha = mode[0];
        m_dord = dord;
        host_wr(A_SPCR, {spie, 1'b1, dord, 1'b0, mode[1], mode[0], 2'b00}, 1'b0);
        @(negedge clk);
        sck = m_cpol;
        repeat (6) @(negedge clk);
    endtask

    task automatic ss_drop();
        @(negedge clk);
        ss_n = 1'b0;
        mdl_loaded = mdl_tx_hold;
        repeat (H) @(negedge clk);
    endtask

    task automatic ss_raise();
        repeat (H) @(negedge clk);
        ss_n = 1'b1;
        repeat (H) @(negedge clk);
    endtask

    // Master side: bit i of the byte in wire order, per CPOL/CPHA/DORD
    task automatic spi_bits(input logic [7:0] mo, input int first, input int count);
        for (int i = first; i < first + count; i++) begin
            int b;
            b = m_dord ? i : 7 - i;
            if (!m_cpha) begin
                mosi = mo[b];
                repeat (H) @(negedge clk);
                m_rx[b] = miso;
                sck = ~m_cpol;
                repeat (H) @(negedge clk);
                sck = m_cpol;
            end else begin
                sck  = ~m_cpol;
                mosi = mo[b];
                repeat (H) @(negedge clk);
                m_rx[b] = miso;
                sck = m_cpol;
                repeat (H) @(negedge clk);
            end
        end
    endtask

    task automatic mdl_byte_done(input logic [7:0] mo);
        mdl_rx_buf = mo;
        mdl_spif   = 1'b1;
    endtask

    task automatic full_xfer(input logic [7:0] tx, input logic [7:0] mo);
        host_wr(A_SPDR, tx, 1'b0);
        ss_drop();
        spi_bits(mo, 0, 8);
        mdl_byte_done(mo);
        ss_raise();
    endtask

    initial begin
        logic [7:0] d;
        rst = 1'b1; wr = 1'b0; rd = 1'b0; int_rst = 1'b0;
        addr = '0; bus_in = '0; sck = 1'b0; ss_n = 1'b1; mosi = 1'b0;
        m_cpol = 1'b0; m_cpha = 1'b0; m_dord = 1'b0; m_rx = '0;
        mdl_tx_hold = '0; mdl_rx_buf = '0; mdl_loaded = '0;
        mdl_spif = 1'b0; mdl_wcol = 1'b0; mdl_armed = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_miso",       8'(miso),       8'h01);
        chk("rst_miso_oe",    8'(miso_oe),    8'h00);
        chk("rst_int_out",    8'(int_out),    8'h00);
        chk("rst_io_connect", 8'(io_connect), 8'h00);
        host_rd(A_SPCR, d); chk("rst_spcr", d, 8'h00);
        host_rd(A_SPSR, d); chk("rst_spsr", d, 8'h00);
        host_rd(A_SPDR, d); chk("rst_spdr", d, 8'h00);

        // Test-plan vectors first, then random ones filled from the model rule
        vecs[0] = '{2'd0, 1'b0, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[1] = '{2'd1, 1'b1, 1'b0, 8'h81, 8'h01, 8'h81, 8'h01};
        vecs[2] = '{2'd2, 1'b1, 1'b0, 8'h81, 8'h01, 8'h81, 8'h01};
        vecs[3] = '{2'd3, 1'b1, 1'b0, 8'h81, 8'h01, 8'h81, 8'h01};
        for (int k = 4; k < 12; k++) begin
            vecs[k].mode     = 2'($urandom_range(0, 3));
            vecs[k].dord     = 1'($urandom_range(0, 1));
            vecs[k].spie     = 1'($urandom_range(0, 1));
            vecs[k].tx       = 8'($urandom_range(0, 255));
            vecs[k].mo       = 8'($urandom_range(0, 255));
            vecs[k].exp_miso = vecs[k].tx;
            vecs[k].exp_spdr = vecs[k].mo;
        end

        for (int k = 0; k < 12; k++) begin
            set_mode(vecs[k].mode, vecs[k].dord, vecs[k].spie);
            full_xfer(vecs[k].tx, vecs[k].mo);
            chk($sformatf("vec%0d_miso_byte", k), m_rx, vecs[k].exp_miso);
            chk($sformatf("vec%0d_int_out", k), 8'(int_out), 8'(vecs[k].spie & mdl_spif));
            host_rd(A_SPSR, d); chk($sformatf("vec%0d_spsr_set", k), d, mdl_spsr());
            host_rd(A_SPDR, d); chk($sformatf("vec%0d_spdr", k), d, vecs[k].exp_spdr);
            host_rd(A_SPSR, d); chk($sformatf("vec%0d_spsr_clr", k), d, mdl_spsr());
        end

        // Interrupt acknowledge alone clears SPIF
        set_mode(2'd0, 1'b0, 1'b1);
        full_xfer(8'h5C, 8'h9E);
        chk("intack_int_set", 8'(int_out), 8'h01);
        pulse_int_rst();
        chk("intack_int_clr", 8'(int_out), 8'h00);
        host_rd(A_SPSR, d); chk("intack_spsr", d, mdl_spsr());
        host_rd(A_SPDR, d); chk("intack_spdr", d, mdl_rx_buf);

        // SS# rises after 4 bits: partial byte discarded, then a full byte
        set_mode(2'd0, 1'b0, 1'b0);
        chk("io_connect_on", 8'(io_connect), 8'h01);
        host_wr(A_SPDR, 8'h33, 1'b0);
        ss_drop();
        chk("abort_miso_oe_on", 8'(miso_oe), 8'h01);
        spi_bits(8'hF0, 0, 4);
        ss_raise();
        chk("abort_miso_oe_off", 8'(miso_oe), 8'h00);
        chk("abort_miso_idle", 8'(miso), 8'h01);
        host_rd(A_SPSR, d); chk("abort_spsr", d, mdl_spsr());
        host_rd(A_SPDR, d); chk("abort_spdr_kept", d, mdl_rx_buf);
        full_xfer(8'h66, 8'h55);
        chk("after_abort_miso", m_rx, 8'h66);
        host_rd(A_SPSR, d); chk("after_abort_spsr", d, mdl_spsr());
        host_rd(A_SPDR, d); chk("after_abort_spdr", d, 8'h55);

        // Back-to-back bytes under one SS#, tx_hold rewritten at the boundary
        set_mode(2'd1, 1'b0, 1'b1);
        host_wr(A_SPDR, 8'h11, 1'b0);
        ss_drop();
        spi_bits(8'hA7, 0, 8);
        mdl_byte_done(8'hA7);
        chk("b2b_first_miso", m_rx, mdl_loaded);
        chk("b2b_first_int", 8'(int_out), 8'(mdl_spif));
        pulse_int_rst();
        host_wr(A_SPDR, 8'h22, 1'b0);
        mdl_loaded = mdl_tx_hold;
        spi_bits(8'h4B, 0, 8);
        mdl_byte_done(8'h4B);
        chk("b2b_second_miso", m_rx, mdl_loaded);
        chk("b2b_second_int", 8'(int_out), 8'(mdl_spif));
        ss_raise();
        host_rd(A_SPSR, d); chk("b2b_spsr", d, mdl_spsr());
        host_rd(A_SPDR, d); chk("b2b_spdr", d, 8'h4B);

        // SPDR written at bit 3 of a live byte
        set_mode(2'd0, 1'b0, 1'b0);
        host_wr(A_SPDR, 8'h5A, 1'b0);
        ss_drop();
        spi_bits(8'h0F, 0, 3);
        host_wr(A_SPDR, 8'hC3, 1'b1);
        spi_bits(8'h0F, 3, 5);
        mdl_byte_done(8'h0F);
        ss_raise();
        chk("wcol_byte_unchanged", m_rx, mdl_loaded);
        host_rd(A_SPSR, d); chk("wcol_spsr", d, mdl_spsr());
        host_rd(A_SPDR, d); chk("wcol_spdr", d, 8'h0F);
        host_rd(A_SPSR, d); chk("wcol_spsr_clr", d, mdl_spsr());
        ss_drop();
        spi_bits(8'h99, 0, 8);
        mdl_byte_done(8'h99);
        ss_raise();
        chk("wcol_next_byte", m_rx, mdl_loaded);
        host_rd(A_SPSR, d); chk("wcol_next_spsr", d, mdl_spsr());

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
